exc_irq_ctrl: RTL and testbench

- Interrupt/exception sequencer for the single-cycle CPU.
- Detects external interrupt edges and synchronous datapath exceptions (overflow, illegal opcode).
- Saves the return address (EPC) and cause, then steers the PC register's input to the exception vector, the interrupt vector, or EPC on return (eret).
- Sits between the next-PC mux and the PC register, and owns the small CP0-style mask/status state.

---
 rtl/exc_irq_ctrl_if.sv | 18 +
 rtl/exc_irq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_exc_irq_ctrl.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/exc_irq_ctrl_if.sv
// CP0-style control register write bus between the CPU datapath and exc_irq_ctrl.
interface exc_irq_ctrl_if;
    logic        cp0_we;
    logic        cp0_sel;
    logic [31:0] cp0_wdata;

    modport master (
        output cp0_we,
        output cp0_sel,
        output cp0_wdata
    );

    modport slave (
        input cp0_we,
        input cp0_sel,
        input cp0_wdata
    );
endinterface

// File: rtl/exc_irq_ctrl.sv
// Interrupt/exception sequencer: captures interrupt edges, saves EPC/cause,
// and steers the PC register input to the handler vectors or back to EPC.
module exc_irq_ctrl #(
    parameter int          NUM_IRQ = 4,
    parameter logic [31:0] EXC_VEC = 32'h8000_0004,
    parameter logic [31:0] IRQ_VEC = 32'h8000_0008
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic [NUM_IRQ-1:0] irq_in,
    input  logic               exc_ovf,
    input  logic               exc_ill,
    input  logic               eret,
    input  logic [31:0]        ia,
    input  logic [31:0]        pc_next,
    exc_irq_ctrl_if.slave      cp0,
    output logic [31:0]        pc_out,
    output logic               flush,
    output logic [NUM_IRQ-1:0] irq_ack,
    output logic [31:0]        epc,
    output logic [31:0]        cause,
    output logic [NUM_IRQ-1:0] mask,
    output logic               ie
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_REDIR   = 2'd1,
        ST_HANDLER = 2'd2,
        ST_RETURN  = 2'd3
    } state_t;

    localparam logic [4:0] CODE_IRQ = 5'd0;
    localparam logic [4:0] CODE_ILL = 5'd10;
    localparam logic [4:0] CODE_OVF = 5'd12;

    state_t               state_q, state_d;
    logic [NUM_IRQ-1:0]   pending_q, pending_d;
    logic [NUM_IRQ-1:0]   irq_in_q, irq_in_d;
    logic [NUM_IRQ-1:0]   mask_q, mask_d;
    logic                 ie_q, ie_d;
    logic [31:0]          epc_q, epc_d;
    logic [31:0]          cause_q, cause_d;
    logic [31:0]          target_q, target_d;

    logic [NUM_IRQ-1:0]   irq_req;
    logic [NUM_IRQ-1:0]   irq_grant;
    logic                 nested;
    logic [4:0]           code;
    logic                 unused_wdata;

    // Only the low bits of the write data are architected.
    assign unused_wdata = ^cp0.cp0_wdata;

    assign irq_req = pending_q & mask_q;

    // Fixed-priority grant: lowest set index wins.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_IRQ; gi++) begin : g_grant
            if (gi == 0) begin : g_first
                assign irq_grant[gi] = irq_req[gi];
            end else begin : g_rest
                assign irq_grant[gi] = irq_req[gi] & ~(|irq_req[gi-1:0]);
            end
        end
    endgenerate

    // Next-state, dispatch decisions and PC steering.
    always_comb begin
        state_d  = state_q;
        mask_d   = mask_q;
        ie_d     = ie_q;
        epc_d    = epc_q;
        cause_d  = cause_q;
        target_d = target_q;
        pc_out   = pc_next;
        flush    = 1'b0;
        irq_ack  = '0;
        nested   = (state_q == ST_HANDLER);
        code     = CODE_IRQ;
        irq_in_d = irq_in;

        case (state_q)
            ST_RUN, ST_HANDLER: begin
                if (!stall) begin
                    // Software writes first so that a dispatch below overrides ie.
                    if (cp0.cp0_we) begin
                        if (cp0.cp0_sel) ie_d   = cp0.cp0_wdata[0];
                        else             mask_d = cp0.cp0_wdata[NUM_IRQ-1:0];
                    end
                    if (exc_ill || exc_ovf || (eret && !nested)) begin
                        // eret outside a handler is an illegal instruction.
                        code     = (!exc_ill && exc_ovf) ? CODE_OVF : CODE_ILL;
                        if (!nested) epc_d = ia;
                        cause_d  = {nested, {(23-NUM_IRQ){1'b0}}, pending_q, 3'b000, code};
                        target_d = EXC_VEC;
                        ie_d     = 1'b0;
                        state_d  = ST_REDIR;
                    end else if (eret) begin
                        state_d = ST_RETURN;
                    end else if (ie_q && (|irq_req)) begin
                        irq_ack  = irq_grant;
                        epc_d    = pc_next;
                        cause_d  = {nested, {(23-NUM_IRQ){1'b0}}, pending_q, 3'b000, CODE_IRQ};
                        target_d = IRQ_VEC;
                        ie_d     = 1'b0;
                        state_d  = ST_REDIR;
                    end
                end
            end
            ST_REDIR: begin
                pc_out = target_q;
                flush  = 1'b1;
                if (!stall) state_d = ST_HANDLER;
            end
            ST_RETURN: begin
                pc_out = epc_q;
                flush  = 1'b1;
                if (!stall) begin
                    ie_d    = 1'b1;
                    state_d = ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase

        // Edge capture runs even while stalled; a fresh edge beats the ack.
        pending_d = (pending_q & ~irq_ack) | (irq_in & ~irq_in_q);
    end

    // State and CP0 registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_RUN;
            pending_q <= '0;
            irq_in_q  <= '0;
            mask_q    <= '0;
            ie_q      <= 1'b0;
            epc_q     <= '0;
            cause_q   <= '0;
            target_q  <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            irq_in_q  <= irq_in_d;
            mask_q    <= mask_d;
            ie_q      <= ie_d;
            epc_q     <= epc_d;
            cause_q   <= cause_d;
            target_q  <= target_d;
        end
    end

    assign epc   = epc_q;
    assign cause = cause_q;
    assign mask  = mask_q;
    assign ie    = ie_q;

endmodule

// File: tb/tb_exc_irq_ctrl.sv
// Directed bench for exc_irq_ctrl: exceptions, interrupts, eret, stall, reset.
module tb_exc_irq_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall;
    logic [3:0]  irq_in;
    logic        exc_ovf;
    logic        exc_ill;
    logic        eret;
    logic [31:0] ia;
    logic [31:0] pc_next;
    logic [31:0] pc_out;
    logic        flush;
    logic [3:0]  irq_ack;
    logic [31:0] epc;
    logic [31:0] cause;
    logic [3:0]  mask;
    logic        ie;

    int checks = 0;
    int errors = 0;

    exc_irq_ctrl_if cp0_bus ();

    exc_irq_ctrl #(
        .NUM_IRQ (4),
        .EXC_VEC (32'h8000_0004),
        .IRQ_VEC (32'h8000_0008)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .stall   (stall),
        .irq_in  (irq_in),
        .exc_ovf (exc_ovf),
        .exc_ill (exc_ill),
        .eret    (eret),
        .ia      (ia),
        .pc_next (pc_next),
        .cp0     (cp0_bus.slave),
        .pc_out  (pc_out),
        .flush   (flush),
        .irq_ack (irq_ack),
        .epc     (epc),
        .cause   (cause),
        .mask    (mask),
        .ie      (ie)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
        $display("[%0t] check %s observed %h", $time, tag, obs);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cp0_write(input logic sel, input logic [31:0] data);
        cp0_bus.cp0_we    = 1'b1;
        cp0_bus.cp0_sel   = sel;
        cp0_bus.cp0_wdata = data;
        tick();
        cp0_bus.cp0_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; irq_in = '0;
        exc_ovf = 1'b0; exc_ill = 1'b0; eret = 1'b0;
        ia = 32'h0; pc_next = 32'h0000_1234;
        cp0_bus.cp0_we = 1'b0; cp0_bus.cp0_sel = 1'b0; cp0_bus.cp0_wdata = '0;
        #1;
        check("rst_flush", {31'b0, flush}, 32'd0);
        check("rst_epc", epc, 32'd0);
        check("rst_cause", cause, 32'd0);
        check("rst_mask", {28'b0, mask}, 32'd0);
        check("rst_ie", {31'b0, ie}, 32'd0);
        check("rst_ack", {28'b0, irq_ack}, 32'd0);
        check("rst_pc_out", pc_out, 32'h0000_1234);
        tick(); tick();
        reset = 1'b0;

        // 1: overflow in RUN
        ia = 32'h8000_0100; pc_next = 32'h8000_0104; exc_ovf = 1'b1;
        tick();
        exc_ovf = 1'b0;
        check("t1_pc_out", pc_out, 32'h8000_0004);
        check("t1_flush", {31'b0, flush}, 32'd1);
        check("t1_epc", epc, 32'h8000_0100);
        check("t1_cause", cause, 32'h0000_000C);
        check("t1_ie", {31'b0, ie}, 32'd0);
        tick();
        check("t1_handler_flush", {31'b0, flush}, 32'd0);
        check("t1_handler_pc", pc_out, 32'h8000_0104);
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t1_ret_pc", pc_out, 32'h8000_0100);
        check("t1_ret_flush", {31'b0, flush}, 32'd1);
        tick();
        check("t1_run_ie", {31'b0, ie}, 32'd1);

        // 2: two simultaneous interrupt edges, lowest enabled index wins
        cp0_write(1'b0, 32'h0000_0006);
        check("t2_mask", {28'b0, mask}, 32'h6);
        cp0_write(1'b1, 32'h0000_0001);
        check("t2_ie", {31'b0, ie}, 32'd1);
        pc_next = 32'h8000_0200; irq_in = 4'b0110;
        tick();
        check("t2_ack", {28'b0, irq_ack}, 32'h2);
        tick();
        check("t2_pc_out", pc_out, 32'h8000_0008);
        check("t2_flush", {31'b0, flush}, 32'd1);
        check("t2_epc", epc, 32'h8000_0200);
        check("t2_cause", cause, 32'h0000_0600);
        check("t2_ack_gone", {28'b0, irq_ack}, 32'h0);
        check("t2_pending", {28'b0, dut.pending_q}, 32'h4);
        tick();
        check("t2_handler_noack", {28'b0, irq_ack}, 32'h0);

        // 3: eret back to EPC, then the remaining pending irq is dispatched
        eret = 1'b1;
        tick();
        eret = 1'b0;
        check("t3_ret_pc", pc_out, 32'h8000_0200);
        check("t3_ret_flush", {31'b0, flush}, 32'd1);
        pc_next = 32'h8000_0300;
        tick();
        check("t3_run_ie", {31'b0, ie}, 32'd1);
        check("t3_ack", {28'b0, irq_ack}, 32'h4);
        tick();
        check("t3_epc", epc, 32'h8000_0300);
        check("t3_cause", cause, 32'h0000_0400);
        tick();
        eret = 1'b1;
        tick();
        eret = 1'b0;
        tick();

        // 4: illegal beats overflow in RUN; nested overflow in HANDLER
        check("t4_run_flush", {31'b0, flush}, 32'd0);
        ia = 32'h8000_0400; exc_ill = 1'b1; exc_ovf = 1'b1;
        tick();
        exc_ill = 1'b0; exc_ovf = 1'b0;
        check("t4_cause_ill", cause, 32'h0000_000A);
        check("t4_epc_ill", epc, 32'h8000_0400);
        tick();
        ia = 32'h8000_0500; exc_ovf = 1'b1;
        tick();
        exc_ovf = 1'b0;
        check("t4_nested_cause", cause, 32'h8000_000C);
        check("t4_nested_epc", epc, 32'h8000_0400);
        check("t4_nested_pc", pc_out, 32'h8000_0004);

        // 5: stall held in REDIR while irq 0 edge arrives
        stall = 1'b1; irq_in = 4'b0111;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_stall_pc", pc_out, 32'h8000_0004);
            check("t5_stall_flush", {31'b0, flush}, 32'd1);
            check("t5_stall_ack", {28'b0, irq_ack}, 32'h0);
        end
        check("t5_pending", {28'b0, dut.pending_q}, 32'h1);
        stall = 1'b0;
        tick();
        check("t5_handler_flush", {31'b0, flush}, 32'd0);
        check("t5_handler_noack", {28'b0, irq_ack}, 32'h0);
        cp0_write(1'b0, 32'h0000_0007);
        cp0_write(1'b1, 32'h0000_0001);
        pc_next = 32'h8000_0600;
        check("t5_nested_ack", {28'b0, irq_ack}, 32'h1);
        tick();
        check("t5_nested_epc", epc, 32'h8000_0600);
        check("t5_nested_cause", cause, 32'h8000_0100);
        check("t5_nested_pc", pc_out, 32'h8000_0008);

        // 6: asynchronous reset in REDIR
        #2;
        reset = 1'b1;
        #1;
        check("t6_flush", {31'b0, flush}, 32'd0);
        check("t6_epc", epc, 32'd0);
        check("t6_cause", cause, 32'd0);
        check("t6_mask", {28'b0, mask}, 32'd0);
        check("t6_ie", {31'b0, ie}, 32'd0);
        check("t6_pc_out", pc_out, 32'h8000_0600);
        tick();
        reset = 1'b0;
        tick();
        check("t6_after_flush", {31'b0, flush}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
